l2_cache_assoc: RTL and testbench
=================================

Name: l2_cache_assoc

Overview:
Parametrised N-way set-associative L2 tag/data/state array and the next generation of the direct-mapped L2 cache array. It keeps the comp/write command semantics: compare-read, compare-write, victim read and fill. It adds the following:
- way selection with tree pseudo-LRU replacement
- a valid/ready request handshake with a registered one-cycle response
- a post-reset invalidation sweep

It sits under the L2 controller FSM, which issues one command at a time and handles eviction and refill to memory.

Parameters:
WAYS, 4, associativity; power of 2, range 2..16
SETS, 128, sets; power of 2
TAG_W, `L2_TAG_WIDTH, tag width
DATA_W, `DATA_WIDTH, line width (512)
OFFSET_W, `L2_OFFSET_WIDTH, byte offset width (6)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block accepts request this cycle
req_comp  in  1  1 = compare (tag lookup); 0 = direct way access
req_write  in  1  1 = write; 0 = read
req_tag  in  TAG_W  request tag
req_index  in  log2(SETS)  set index
req_offset  in  OFFSET_W  byte offset; must be 0
req_way  in  log2(WAYS)  target way when req_comp=0; ignored otherwise
req_data  in  DATA_W  write line
req_valid_bit  in  1  valid value written on fill
rsp_valid  out  1  response present, one cycle after accept
rsp_hit  out  1  compare op matched a valid way
rsp_way  out  log2(WAYS)  hit way; on miss, victim way; on direct ops, echoes req_way
rsp_tag  out  TAG_W  tag of rsp_way
rsp_data  out  DATA_W  line of rsp_way; 0 on any write
rsp_dirty  out  1  dirty bit of rsp_way
rsp_line_valid  out  1  valid bit of rsp_way
rsp_err  out  1  req_offset nonzero

Behaviour:
- Reset (rst=0 sampled on a clock edge):
  - all rsp_* outputs go to 0; req_ready=0
  - FSM enters INIT with the sweep counter at 0
- FSM has two states, INIT and RUN.
- INIT:
  - each cycle clears valid, dirty and PLRU bits of set[counter], then increments the counter
  - after set SETS-1 is cleared, the next state is RUN
  - INIT takes exactly SETS cycles; req_ready=0 throughout
  - data and tag arrays are not cleared
- RUN: req_ready=1 every cycle.
- A request is accepted when req_valid & req_ready. All array and PLRU updates commit at that edge. The response is registered and appears in the next cycle with rsp_valid=1 for one cycle.
- A back-to-back request to the same set sees the prior update (no hazard).
- Commands (hit = some way with valid & tag==req_tag; ways are unique by construction):
  - comp=1, write=0: returns the hit way's tag/data/dirty; on hit, PLRU is touched. On miss, rsp_way is the victim and the victim's tag/dirty/valid/data are returned.
  - comp=1, write=1: on hit, writes data to the hit way, sets dirty=1, touches PLRU. On miss, writes nothing and returns the victim plus its dirty/valid.
  - comp=0, write=0: reads req_way (eviction read); no state change.
  - comp=0, write=1: fill of req_way. Writes data, tag and valid=req_valid_bit, clears dirty, touches PLRU.
- Victim selection: lowest-index invalid way; if all ways are valid, the PLRU victim.
- rsp_err=1 if req_offset!=0. In that case the request is inhibited (no array/PLRU writes) and rsp_hit=0.
- PLRU: tree of WAYS-1 bits per set. A touch points every node on the accessed way's path away from it. The victim is found by following the node bits from the root.
- rst low while in RUN with a response pending: the response is dropped (rsp_valid=0 next cycle) and INIT restarts at set 0.
- req_valid while req_ready=0 has no effect; the requester holds the request.

Decomposition:
- Shared constants (`L2_TAG_WIDTH`, `DATA_WIDTH`, `L2_OFFSET_WIDTH`) stay in mem_sys_constants.sv.
- Add to that file:
  - `L2_WAYS` and `L2_SETS` defaults
  - a 2-bit command encoding {comp, write} as named constants for the controller
- One sub-module, l2_plru_tree: combinational.
  - Inputs: one set's PLRU bits, touch way, touch enable.
  - Outputs: next PLRU bits and victim way.
  - Parametrised by WAYS.

Test Plan:
- Reset, then count cycles: req_ready rises exactly SETS=128 cycles after rst returns high. A compare-read of every set then gives rsp_hit=0, rsp_line_valid=0, rsp_way=0.
- Fill index 5 ways 0..3 with tags 0x10..0x13 (valid_bit=1), then compare-read tag 0x12: response the next cycle has rsp_hit=1, rsp_way=2, data matches, rsp_dirty=0.
- Compare-write tag 0x11 at index 5, then compare-read tag 0x11: rsp_hit=1, rsp_dirty=1, new data returned. A compare-write of tag 0x99 gives rsp_hit=0 and no array change.
- PLRU: after filling ways 0,1,2,3 in order at index 5, a compare-read of tag 0x77 reports rsp_way=0. After touching way 0, the victim is 2.
- req_offset=6'h04 on a compare-write of a resident tag: rsp_err=1, rsp_hit=0. A subsequent compare-read shows the old data and dirty=0.
- Drive rst low for one cycle while a request is in flight: no rsp_valid the next cycle, req_ready=0 for 128 cycles, and all lines read back invalid.

Source files
------------

// File: rtl/l2_cache_assoc_pkg.sv
// rtl/l2_cache_assoc_pkg.sv - state and command types shared by the set-associative L2 array
`ifndef MEM_SYS_CONSTANTS_SV
`include "mem_sys_constants.sv"
`endif

package l2_cache_assoc_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } l2_state_e;

    typedef enum logic [1:0] {
        CMD_DIRECT_READ = `L2_CMD_DIRECT_READ,
        CMD_FILL        = `L2_CMD_FILL,
        CMD_COMP_READ   = `L2_CMD_COMP_READ,
        CMD_COMP_WRITE  = `L2_CMD_COMP_WRITE
    } l2_cmd_e;

endpackage

// File: rtl/l2_plru_tree.sv
// rtl/l2_plru_tree.sv - combinational tree pseudo-LRU update and victim walk for one set
module l2_plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         plru_in,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    input  logic                    touch_en,
    output logic [WAYS-2:0]         plru_out,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int LVL = $clog2(WAYS);
    localparam int NW  = LVL + 1;

    // Heap layout: node n has children 2n+1 (left) and 2n+2 (right); bit=0 means victim is left.
    logic [2*WAYS-1:0] tree;
    logic [2*WAYS-1:0] src;
    logic [NW-1:0]     node;
    logic [NW-1:0]     vnode;
    logic              b;

    always_comb begin
        tree       = '0;
        src        = '0;
        node       = '0;
        vnode      = '0;
        b          = 1'b0;
        victim_way = '0;
        tree[WAYS-2:0] = plru_in;
        src[WAYS-2:0]  = plru_in;
        for (int l = 0; l < LVL; l++) begin
            b = touch_way[LVL-1-l];
            if (touch_en) begin
                tree[node] = ~b;
            end
            node = {node[NW-2:0], 1'b0} + NW'(1) + {{(NW-1){1'b0}}, b};
        end
        for (int l = 0; l < LVL; l++) begin
            victim_way[LVL-1-l] = src[vnode];
            vnode = {vnode[NW-2:0], 1'b0} + NW'(1) + {{(NW-1){1'b0}}, src[vnode]};
        end
        plru_out = tree[WAYS-2:0];
    end

endmodule

// File: rtl/mem_sys_constants.sv
// rtl/mem_sys_constants.sv - shared memory-system widths, L2 geometry defaults and L2 command codes
`ifndef MEM_SYS_CONSTANTS_SV
`define MEM_SYS_CONSTANTS_SV

`define L2_TAG_WIDTH     20
`define DATA_WIDTH       512
`define L2_OFFSET_WIDTH  6
`define L2_WAYS          4
`define L2_SETS          128

// {comp, write} as driven by the L2 controller
`define L2_CMD_DIRECT_READ 2'b00
`define L2_CMD_FILL        2'b01
`define L2_CMD_COMP_READ   2'b10
`define L2_CMD_COMP_WRITE  2'b11

`endif

// File: rtl/l2_cache_assoc.sv
// rtl/l2_cache_assoc.sv - N-way set-associative L2 tag/data/state array with PLRU and init sweep
import l2_cache_assoc_pkg::*;

module l2_cache_assoc #(
    parameter int WAYS     = `L2_WAYS,
    parameter int SETS     = `L2_SETS,
    parameter int TAG_W    = `L2_TAG_WIDTH,
    parameter int DATA_W   = `DATA_WIDTH,
    parameter int OFFSET_W = `L2_OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_comp,
    input  logic                    req_write,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic [$clog2(SETS)-1:0] req_index,
    input  logic [OFFSET_W-1:0]     req_offset,
    input  logic [$clog2(WAYS)-1:0] req_way,
    input  logic [DATA_W-1:0]       req_data,
    input  logic                    req_valid_bit,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [$clog2(WAYS)-1:0] rsp_way,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_dirty,
    output logic                    rsp_line_valid,
    output logic                    rsp_err
);

    localparam int LVL   = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);

    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-1:0]   dirty_mem [SETS];
    logic [WAYS-2:0]   plru_mem  [SETS];

    l2_state_e         state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;

    l2_cmd_e           cmd;
    logic              accept, err, do_op;
    logic [WAYS-1:0]   set_valid, set_dirty;
    logic              hit, any_inv;
    logic [LVL-1:0]    hit_way, inv_way, victim_way, sel_way;
    logic [WAYS-2:0]   plru_next;
    logic              touch_en, data_we, tag_we, fill_we, dirty_we;

    logic              rsp_valid_d, rsp_hit_d, rsp_dirty_d, rsp_line_valid_d, rsp_err_d;
    logic [LVL-1:0]    rsp_way_d;
    logic [TAG_W-1:0]  rsp_tag_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_valid_q, rsp_hit_q, rsp_dirty_q, rsp_line_valid_q, rsp_err_q;
    logic [LVL-1:0]    rsp_way_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [DATA_W-1:0] rsp_data_q;

    l2_plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_in    (plru_mem[req_index]),
        .touch_way  (sel_way),
        .touch_en   (touch_en),
        .plru_out   (plru_next),
        .victim_way (victim_way)
    );

    always_comb begin
        cmd       = l2_cmd_e'({req_comp, req_write});
        accept    = req_valid & ready_q;
        err       = |req_offset;
        do_op     = accept & ~err;
        set_valid = valid_mem[req_index];
        set_dirty = dirty_mem[req_index];
        hit       = 1'b0;
        hit_way   = '0;
        any_inv   = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && tag_mem[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = w[LVL-1:0];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                any_inv = 1'b1;
                inv_way = w[LVL-1:0];
            end
        end
        if (req_comp) begin
            sel_way = hit ? hit_way : (any_inv ? inv_way : victim_way);
        end else begin
            sel_way = req_way;
        end
    end

    always_comb begin
        touch_en = 1'b0;
        data_we  = 1'b0;
        tag_we   = 1'b0;
        fill_we  = 1'b0;
        dirty_we = 1'b0;
        case (cmd)
            CMD_COMP_READ: begin
                touch_en = do_op & hit;
            end
            CMD_COMP_WRITE: begin
                touch_en = do_op & hit;
                data_we  = do_op & hit;
                dirty_we = do_op & hit;
            end
            CMD_FILL: begin
                touch_en = do_op;
                data_we  = do_op;
                tag_we   = do_op;
                fill_we  = do_op;
            end
            default: begin
            end
        endcase
    end

    // Response describes the selected way after this access's own update.
    always_comb begin
        rsp_valid_d      = accept;
        rsp_hit_d        = 1'b0;
        rsp_way_d        = '0;
        rsp_tag_d        = '0;
        rsp_data_d       = '0;
        rsp_dirty_d      = 1'b0;
        rsp_line_valid_d = 1'b0;
        rsp_err_d        = 1'b0;
        if (accept) begin
            rsp_hit_d        = req_comp & hit & ~err;
            rsp_way_d        = sel_way;
            rsp_tag_d        = tag_we ? req_tag : tag_mem[req_index][sel_way];
            rsp_data_d       = req_write ? '0 : data_mem[req_index][sel_way];
            rsp_dirty_d      = dirty_we | (~fill_we & set_dirty[sel_way]);
            rsp_line_valid_d = fill_we ? req_valid_bit : set_valid[sel_way];
            rsp_err_d        = err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                valid_mem[cnt_q] <= '0;
                dirty_mem[cnt_q] <= '0;
                plru_mem[cnt_q]  <= '0;
            end else begin
                if (touch_en) begin
                    plru_mem[req_index] <= plru_next;
                end
                if (fill_we) begin
                    valid_mem[req_index][req_way] <= req_valid_bit;
                    dirty_mem[req_index][req_way] <= 1'b0;
                end
                if (dirty_we) begin
                    dirty_mem[req_index][sel_way] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && data_we) begin
            data_mem[req_index][sel_way] <= req_data;
        end
        if (rst && tag_we) begin
            tag_mem[req_index][req_way] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q      <= 1'b0;
            rsp_hit_q        <= 1'b0;
            rsp_way_q        <= '0;
            rsp_tag_q        <= '0;
            rsp_data_q       <= '0;
            rsp_dirty_q      <= 1'b0;
            rsp_line_valid_q <= 1'b0;
            rsp_err_q        <= 1'b0;
        end else begin
            rsp_valid_q      <= rsp_valid_d;
            rsp_hit_q        <= rsp_hit_d;
            rsp_way_q        <= rsp_way_d;
            rsp_tag_q        <= rsp_tag_d;
            rsp_data_q       <= rsp_data_d;
            rsp_dirty_q      <= rsp_dirty_d;
            rsp_line_valid_q <= rsp_line_valid_d;
            rsp_err_q        <= rsp_err_d;
        end
    end

    assign req_ready      = ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_way        = rsp_way_q;
    assign rsp_tag        = rsp_tag_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_dirty      = rsp_dirty_q;
    assign rsp_line_valid = rsp_line_valid_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb/tb_l2_cache_assoc.sv - directed self-checking bench for l2_cache_assoc
module tb_l2_cache_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_comp, req_write;
    logic [19:0]  req_tag;
    logic [6:0]   req_index;
    logic [5:0]   req_offset;
    logic [1:0]   req_way;
    logic [511:0] req_data;
    logic         req_valid_bit;
    logic         rsp_valid, rsp_hit, rsp_dirty, rsp_line_valid, rsp_err;
    logic [1:0]   rsp_way;
    logic [19:0]  rsp_tag;
    logic [511:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int n;

    logic [511:0] new_d = {16{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    l2_cache_assoc #(
        .WAYS(4), .SETS(128), .TAG_W(20), .DATA_W(512), .OFFSET_W(6)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_comp(req_comp), .req_write(req_write),
        .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
        .req_way(req_way), .req_data(req_data), .req_valid_bit(req_valid_bit),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_dirty(rsp_dirty),
        .rsp_line_valid(rsp_line_valid), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] dat(input int w);
        logic [31:0] word;
        word = 32'hA500_0000 | 32'(w);
        return {16{word}};
    endfunction

    task automatic issue(input logic comp, input logic write, input logic [19:0] tag,
                         input logic [6:0] idx, input logic [5:0] off, input logic [1:0] way,
                         input logic [511:0] data, input logic vb);
        @(negedge clk);
        req_comp = comp; req_write = write; req_tag = tag; req_index = idx;
        req_offset = off; req_way = way; req_data = data; req_valid_bit = vb;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_valid", rsp_valid, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (cnt < 1000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (req_ready) break;
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_comp = 1'b0; req_write = 1'b0;
        req_tag = '0; req_index = '0; req_offset = '0; req_way = '0;
        req_data = '0; req_valid_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_hit", rsp_hit, 0);
        check("reset_rsp_err", rsp_err, 0);

        @(negedge clk);
        rst = 1'b1;
        wait_ready(n);
        check("init_cycles", n, 128);

        for (int s = 0; s < 128; s++) begin
            issue(1'b1, 1'b0, 20'h0, 7'(s), 6'h0, 2'd0, '0, 1'b0);
            check("init_hit", rsp_hit, 0);
            check("init_line_valid", rsp_line_valid, 0);
            check("init_way", rsp_way, 0);
        end
        idle();
        @(posedge clk);
        #1;
        check("rsp_one_cycle", rsp_valid, 0);

        for (int w = 0; w < 4; w++) begin
            issue(1'b0, 1'b1, 20'(32'h10 + w), 7'd5, 6'h0, 2'(w), dat(w), 1'b1);
            check("fill_rsp_data", rsp_data, 0);
        end
        issue(1'b1, 1'b0, 20'h12, 7'd5, 6'h0, 2'd0, '0, 1'b0);
        check("rd12_hit", rsp_hit, 1);
        check("rd12_way", rsp_way, 2);
        check("rd12_data", rsp_data, dat(2));
        check("rd12_dirty", rsp_dirty, 0);
        check("rd12_tag", rsp_tag, 20'h12);

        issue(1'b1, 1'b1, 20'h11, 7'd5, 6'h0, 2'd0, new_d, 1'b0);
        check("cw11_hit", rsp_hit, 1);
        check("cw11_way", rsp_way, 1);
        check("cw11_data", rsp_data, 0);
        issue(1'b1, 1'b0, 20'h11, 7'd5, 6'h0, 2'd0, '0, 1'b0);
        check("rd11_hit", rsp_hit, 1);
        check("rd11_dirty", rsp_dirty, 1);
        check("rd11_data", rsp_data, new_d);

        issue(1'b1, 1'b1, 20'h99, 7'd5, 6'h0, 2'd0, {16{32'h5555_5555}}, 1'b0);
        check("cw99_hit", rsp_hit, 0);
        for (int w = 0; w < 4; w++) begin
            issue(1'b1, 1'b0, 20'(32'h10 + w), 7'd5, 6'h0, 2'd0, '0, 1'b0);
            check("after99_hit", rsp_hit, 1);
            check("after99_data", rsp_data, (w == 1) ? new_d : dat(w));
        end

        for (int w = 0; w < 4; w++) begin
            issue(1'b0, 1'b1, 20'(32'h20 + w), 7'd9, 6'h0, 2'(w), dat(w + 8), 1'b1);
        end
        issue(1'b1, 1'b0, 20'h77, 7'd9, 6'h0, 2'd0, '0, 1'b0);
        check("plru1_hit", rsp_hit, 0);
        check("plru1_way", rsp_way, 0);
        check("plru1_line_valid", rsp_line_valid, 1);
        check("plru1_tag", rsp_tag, 20'h20);
        check("plru1_data", rsp_data, dat(8));
        issue(1'b1, 1'b0, 20'h20, 7'd9, 6'h0, 2'd0, '0, 1'b0);
        check("touch0_hit", rsp_hit, 1);
        check("touch0_way", rsp_way, 0);
        issue(1'b1, 1'b0, 20'h77, 7'd9, 6'h0, 2'd0, '0, 1'b0);
        check("plru2_way", rsp_way, 2);
        check("plru2_tag", rsp_tag, 20'h22);

        issue(1'b0, 1'b1, 20'h30, 7'd12, 6'h0, 2'd0, dat(0), 1'b1);
        issue(1'b0, 1'b1, 20'h32, 7'd12, 6'h0, 2'd2, dat(2), 1'b1);
        issue(1'b1, 1'b0, 20'h77, 7'd12, 6'h0, 2'd0, '0, 1'b0);
        check("inv_hit", rsp_hit, 0);
        check("inv_way", rsp_way, 1);
        check("inv_line_valid", rsp_line_valid, 0);

        issue(1'b1, 1'b1, 20'h13, 7'd5, 6'h04, 2'd0, new_d, 1'b0);
        check("err_flag", rsp_err, 1);
        check("err_hit", rsp_hit, 0);
        issue(1'b1, 1'b0, 20'h13, 7'd5, 6'h0, 2'd0, '0, 1'b0);
        check("post_err_flag", rsp_err, 0);
        check("post_err_hit", rsp_hit, 1);
        check("post_err_data", rsp_data, dat(3));
        check("post_err_dirty", rsp_dirty, 0);

        issue(1'b0, 1'b0, 20'h0, 7'd5, 6'h0, 2'd1, '0, 1'b0);
        check("dir_way", rsp_way, 1);
        check("dir_tag", rsp_tag, 20'h11);
        check("dir_data", rsp_data, new_d);
        check("dir_dirty", rsp_dirty, 1);
        check("dir_line_valid", rsp_line_valid, 1);
        check("dir_hit", rsp_hit, 0);

        @(negedge clk);
        req_comp = 1'b1; req_write = 1'b0; req_tag = 20'h12; req_index = 7'd5;
        req_offset = 6'h0; req_valid = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_drop_valid", rsp_valid, 0);
        check("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        wait_ready(n);
        check("reinit_cycles", n, 128);

        for (int s = 0; s < 128; s++) begin
            issue(1'b1, 1'b0, 20'h12, 7'(s), 6'h0, 2'd0, '0, 1'b0);
            check("reinit_hit", rsp_hit, 0);
            check("reinit_line_valid", rsp_line_valid, 0);
        end
        issue(1'b1, 1'b0, 20'h20, 7'd9, 6'h0, 2'd0, '0, 1'b0);
        check("reinit9_hit", rsp_hit, 0);
        check("reinit9_way", rsp_way, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
